// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, ALU
// control codes, data-processing commands, condition codes, flag indices.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [3:0] ALUCTL_ADD = 4'd0;
    localparam logic [3:0] ALUCTL_SUB = 4'd1;
    localparam logic [3:0] ALUCTL_AND = 4'd2;
    localparam logic [3:0] ALUCTL_ORR = 4'd3;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // ALU operation for a data-processing command; unknown commands add.
    function automatic logic [3:0] alu_ctl_for_cmd(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD:          return ALUCTL_ADD;
            CMD_SUB, CMD_CMP: return ALUCTL_SUB;
            CMD_AND:          return ALUCTL_AND;
            CMD_ORR:          return ALUCTL_ORR;
            default:          return ALUCTL_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: decoded instruction and ALU flags in,
// control strobes and mux selects out.
interface multicycle_controller_if #(
    parameter int ALU_CTRL_W = 4
);
    logic [19:0]           Instr;
    logic [3:0]            ALUFlags;
    logic                  PCWrite;
    logic                  AdrSrc;
    logic                  MemWrite;
    logic                  IRWrite;
    logic                  RegWrite;
    logic [1:0]            RegSrc;
    logic [1:0]            ImmSrc;
    logic                  ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [ALU_CTRL_W-1:0] ALUControl;
    logic [1:0]            ResultSrc;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ALUControl, ResultSrc
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ALUControl, ResultSrc
    );
endinterface

// File: rtl/cond_check.sv
// ARM condition-code evaluation against the stored NZCV flags.
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);
    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    // Map the condition field to pass/fail; 1111 never executes.
    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = ~z & (n == v);
            COND_LE: cond_ex_o = z | (n != v);
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM sequencing controller: Moore FSM over the shared-memory
// datapath, NZCV flag register and condition-gated architectural writes.
module multicycle_controller
    import arm_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       condex_q, condex_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       cond_ex;
    logic       is_cmp, is_arith, dp_writes;

    logic       pc_write, mem_write, ir_write, reg_write;
    logic       adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src;
    logic [3:0] alu_ctl;

    // Rn is consumed by the datapath only.
    logic       unused_rn;
    assign unused_rn = &{1'b0, bus.Instr[7:4]};

    assign cond  = bus.Instr[19:16];
    assign op    = bus.Instr[15:14];
    assign funct = bus.Instr[13:8];
    assign rd    = bus.Instr[3:0];
    assign cmd   = funct[4:1];

    assign is_cmp    = (cmd == CMD_CMP);
    assign is_arith  = (cmd == CMD_ADD) || (cmd == CMD_SUB) || is_cmp;
    assign dp_writes = (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
                       (cmd == CMD_AND) || (cmd == CMD_ORR);

    cond_check u_cond_check (
        .cond_i    (cond),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex)
    );

    // State, flag and latched-condition registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            flags_q  <= '0;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    // Next state, flag update and Moore control outputs per state.
    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        condex_d   = condex_q;
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_ctl    = ALUCTL_ADD;
        unique case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                condex_d  = cond_ex;
                case (op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                alu_ctl   = funct[3] ? ALUCTL_ADD : ALUCTL_SUB;
                state_d   = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                if (rd == 4'hF) pc_write  = condex_q;
                else            reg_write = condex_q;
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = condex_q;
                state_d   = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
                alu_src_b = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
                alu_ctl   = alu_ctl_for_cmd(cmd);
                if (condex_q && funct[0]) begin
                    flags_d[FLAG_N] = bus.ALUFlags[FLAG_N];
                    flags_d[FLAG_Z] = bus.ALUFlags[FLAG_Z];
                    if (is_arith) begin
                        flags_d[FLAG_C] = bus.ALUFlags[FLAG_C];
                        flags_d[FLAG_V] = bus.ALUFlags[FLAG_V];
                    end
                end
                state_d = is_cmp ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                result_src = 2'b00;
                if (dp_writes) begin
                    if (rd == 4'hF) pc_write  = condex_q;
                    else            reg_write = condex_q;
                end
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b0;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = condex_q;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write strobes are forced low for the whole reset cycle.
    assign bus.PCWrite    = pc_write  & ~reset;
    assign bus.MemWrite   = mem_write & ~reset;
    assign bus.IRWrite    = ir_write  & ~reset;
    assign bus.RegWrite   = reg_write & ~reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUControl = ALU_CTRL_W'(alu_ctl);
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {(op == 2'b01) && !funct[0], (op == 2'b10)};
endmodule
